// File: rtl/nibble_serial_logic_unit_pkg.sv
// Shared encodings for the nibble-serial logic unit.
// Used by the top (FSM, counter) and by the combinational slice.
package nibble_serial_logic_unit_pkg;

  typedef enum logic [1:0] {
    OP_AND = 2'b00,
    OP_OR  = 2'b01,
    OP_XOR = 2'b10,
    OP_NOR = 2'b11
  } op_t;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RUN  = 2'b01,
    FIN  = 2'b10
  } state_t;

  localparam int NIBBLES = 8;
  localparam logic [2:0] LAST_NIB = 3'(NIBBLES - 1);

endpackage

// File: rtl/nibble_logic_slice.sv
// 4-bit combinational logic slice, reused once per nibble.
// Computes AND / OR / XOR / NOR of X and Y.
module nibble_logic_slice
  import nibble_serial_logic_unit_pkg::*;
(
  input  logic [3:0] X,
  input  logic [3:0] Y,
  input  op_t        OP,
  output logic [3:0] RES
);

  always_comb begin
    RES = '0;
    unique case (OP)
      OP_AND: RES = X & Y;
      OP_OR:  RES = X | Y;
      OP_XOR: RES = X ^ Y;
      OP_NOR: RES = ~(X | Y);
    endcase
  end

endmodule

// File: rtl/nibble_serial_logic_unit.sv
// Multi-cycle 32-bit logic unit: one 4-bit slice over 8 cycles, LSB first.
// Optional ZERO flag register enabled by defining NSLU_ZERO_FLAG_EN.
module nibble_serial_logic_unit
  import nibble_serial_logic_unit_pkg::*;
(
  input  logic        CLK,
  input  logic        RST,
  input  logic        START,
  input  logic [1:0]  OP,
  input  logic [31:0] A,
  input  logic [31:0] B,
  output logic [31:0] R,
  output logic        BUSY,
  output logic        DONE
`ifdef NSLU_ZERO_FLAG_EN
  ,
  output logic        ZERO
`endif
);

  state_t      state;
  state_t      nxt;
  logic [2:0]  cnt;
  logic [31:0] a_sh;
  logic [31:0] b_sh;
  logic [31:0] res_sh;
  logic [31:0] res_full;
  op_t         op_q;
  logic [3:0]  nib;
  logic        load;
  logic        step;
  logic        fin;

  nibble_logic_slice u_slice (
    .X   (a_sh[3:0]),
    .Y   (b_sh[3:0]),
    .OP  (op_q),
    .RES (nib)
  );

  assign res_full = {nib, res_sh[31:4]};
  assign BUSY     = (state == RUN);
  assign DONE     = (state == FIN);

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) state <= IDLE;
    else     state <= nxt;
  end

  always_comb begin
    nxt  = state;
    load = 1'b0;
    step = 1'b0;
    fin  = 1'b0;
    case (state)
      IDLE: begin
        if (START) begin
          load = 1'b1;
          nxt  = RUN;
        end
      end
      RUN: begin
        step = 1'b1;
        if (cnt == LAST_NIB) begin
          fin = 1'b1;
          nxt = FIN;
        end
      end
      FIN: begin
        // Launching from FIN keeps the back-to-back period at 9 cycles
        if (START) begin
          load = 1'b1;
          nxt  = RUN;
        end else begin
          nxt  = IDLE;
        end
      end
      default: nxt = IDLE;
    endcase
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      cnt    <= '0;
      a_sh   <= '0;
      b_sh   <= '0;
      res_sh <= '0;
      op_q   <= OP_AND;
    end else if (load) begin
      cnt    <= '0;
      a_sh   <= A;
      b_sh   <= B;
      res_sh <= '0;
      op_q   <= op_t'(OP);
    end else if (step) begin
      cnt    <= cnt + 3'd1;
      a_sh   <= {4'h0, a_sh[31:4]};
      b_sh   <= {4'h0, b_sh[31:4]};
      res_sh <= res_full;
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST)      R <= '0;
    else if (fin) R <= res_full;
  end

`ifdef NSLU_ZERO_FLAG_EN
  always_ff @(posedge CLK or posedge RST) begin
    if (RST)      ZERO <= 1'b1;
    else if (fin) ZERO <= (res_full == 32'h0);
  end
`endif

endmodule

// File: tb/tb_nibble_serial_logic_unit.sv
// Bench for nibble_serial_logic_unit: per-cycle model compare plus directed
// literal checks. Define NSLU_ZERO_FLAG_EN to also cover the ZERO flag.
module tb_nibble_serial_logic_unit;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [1:0]  op = 2'b00;
  logic [31:0] a = '0;
  logic [31:0] b = '0;
  logic [31:0] r;
  logic        busy;
  logic        done;
`ifdef NSLU_ZERO_FLAG_EN
  logic        zero;
`endif

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;

  nibble_serial_logic_unit dut (
    .CLK   (clk),
    .RST   (rst),
    .START (start),
    .OP    (op),
    .A     (a),
    .B     (b),
    .R     (r),
    .BUSY  (busy),
    .DONE  (done)
`ifdef NSLU_ZERO_FLAG_EN
    ,
    .ZERO  (zero)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  function automatic logic [31:0] ref_op(input logic [1:0] o,
                                         input logic [31:0] x,
                                         input logic [31:0] y);
    case (o)
      2'b00:   return x & y;
      2'b01:   return x | y;
      2'b10:   return x ^ y;
      default: return ~(x | y);
    endcase
  endfunction

  // Model: k = edges elapsed since the accepting START edge (-1 = idle).
  // Busy for k in 0..7, done at k == 8, result lands at k == 8.
  int          k = -1;
  logic [31:0] pend = '0;
  logic [31:0] exp_r = '0;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      k = -1;
      exp_r = '0;
    end else if ((k < 0 || k == 8) && start) begin
      k = 0;
      pend = ref_op(op, a, b);
    end else if (k >= 0 && k < 8) begin
      k++;
      if (k == 8) exp_r = pend;
    end else begin
      k = -1;
    end
  end

  always @(negedge clk) begin
    cyc++;
    chk("model_busy", {31'b0, busy}, {31'b0, (k >= 0 && k < 8)});
    chk("model_done", {31'b0, done}, {31'b0, (k == 8)});
    chk("model_r", r, exp_r);
`ifdef NSLU_ZERO_FLAG_EN
    chk("model_zero", {31'b0, zero}, {31'b0, (exp_r == 32'h0)});
`endif
  end

  int last_done_cyc = 0;

  // Issue one op and wait for DONE; checks latency and result literal.
  task automatic run_op(input string nm, input bit now, input logic [1:0] o,
                        input logic [31:0] x, input logic [31:0] y,
                        input logic [31:0] exp, input bit exp_z);
    int n;
    bit seen;
    if (!now) @(negedge clk);
    start = 1'b1;
    op = o;
    a = x;
    b = y;
    n = 0;
    seen = 0;
    while (!seen && n < 20) begin
      @(negedge clk);
      n++;
      if (n == 1) start = 1'b0;
      if (done) seen = 1;
    end
    if (!seen) begin
      vectors++;
      miscompares++;
      $display("FAIL %s_timeout: got no DONE expected DONE within 20", nm);
    end else begin
      chk({nm, "_latency"}, 32'(n - 1), 32'd8);
      chk({nm, "_r"}, r, exp);
`ifdef NSLU_ZERO_FLAG_EN
      chk({nm, "_zero"}, {31'b0, zero}, {31'b0, exp_z});
`else
      if (exp_z) chk({nm, "_rz"}, r, 32'h0);
`endif
      last_done_cyc = cyc;
    end
  endtask

  initial begin
    int ndone;
    int d1;
    logic [31:0] rseen;

    repeat (2) @(negedge clk);
    rst = 1'b0;
    chk("reset_r", r, 32'h0);
    chk("reset_busy", {31'b0, busy}, 32'h0);
    chk("reset_done", {31'b0, done}, 32'h0);
`ifdef NSLU_ZERO_FLAG_EN
    chk("reset_zero", {31'b0, zero}, 32'h1);
`endif

    run_op("or", 0, 2'b01, 32'hF0F00000, 32'h0F0F0001, 32'hFFFF0001, 0);

    // NOR; R must hold the OR result mid-run
    @(negedge clk);
    start = 1'b1; op = 2'b11; a = 32'hFFFFFFFF; b = 32'h0;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    chk("nor_hold_r", r, 32'hFFFF0001);
    chk("nor_busy_mid", {31'b0, busy}, 32'h1);
    ndone = 0;
    repeat (10) begin
      @(negedge clk);
      if (done) begin
        ndone++;
        chk("nor_r", r, 32'h00000000);
      end
    end
    chk("nor_ndone", 32'(ndone), 32'd1);

    // Back-to-back: second START presented during the DONE cycle
    run_op("xor", 0, 2'b10, 32'h12345678, 32'hFFFFFFFF, 32'hEDCBA987, 0);
    d1 = last_done_cyc;
    run_op("and", 1, 2'b00, 32'hDEADBEEF, 32'h0000FFFF, 32'h0000BEEF, 0);
    chk("b2b_period", 32'(last_done_cyc - d1), 32'd9);

    // START held and operands changed during RUN
    @(negedge clk);
    start = 1'b1; op = 2'b00; a = 32'hFFFF0000; b = 32'h0F0F0F0F;
    ndone = 0;
    rseen = '0;
    for (int n = 1; n <= 20; n++) begin
      @(negedge clk);
      if (n == 2) begin
        op = 2'b01; a = 32'h0; b = 32'hFFFFFFFF;
      end
      if (n == 5) start = 1'b0;
      if (done) begin
        ndone++;
        rseen = r;
      end
    end
    chk("hold_ndone", 32'(ndone), 32'd1);
    chk("hold_r", rseen, 32'h0F0F0000);

    // Reset in the middle of RUN aborts with no DONE
    @(negedge clk);
    start = 1'b1; op = 2'b01; a = 32'h1; b = 32'h2;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    chk("abort_busy", {31'b0, busy}, 32'h0);
    chk("abort_done", {31'b0, done}, 32'h0);
    chk("abort_r", r, 32'h0);
`ifdef NSLU_ZERO_FLAG_EN
    chk("abort_zero", {31'b0, zero}, 32'h1);
`endif
    @(negedge clk);
    rst = 1'b0;
    ndone = 0;
    repeat (12) begin
      @(negedge clk);
      if (done) ndone++;
    end
    chk("abort_ndone", 32'(ndone), 32'd0);

    run_op("post", 0, 2'b10, 32'hA5A5A5A5, 32'h0F0F0F0F, 32'hAAAAAAAA, 0);
    run_op("nor2", 0, 2'b11, 32'h0F0F0F0F, 32'h00FF00FF, 32'hF000F000, 0);

    repeat (3) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL global_timeout: got hang expected finish");
    $fatal(1, "timeout");
  end

endmodule
